// File: rtl/lcd_rx_pkg.sv
// Shared constants and decode helpers for the HD44780 4-bit bus receiver.
// Holds the command prefix table, DDRAM line layout and shadow-buffer geometry.
package lcd_rx_pkg;

   localparam int LINE_LEN  = 16;
   localparam int LINES     = 2;
   localparam int BUF_DEPTH = LINE_LEN * LINES;

   localparam logic [6:0] LINE1_BASE = 7'h00;
   localparam logic [6:0] LINE2_BASE = 7'h40;
   localparam logic [7:0] BLANK_CHAR = 8'h20;

   // Each command is identified by its leading one; the mask covers that bit and everything above it.
   localparam logic [7:0] CMD_DDRAM_MASK   = 8'h80, CMD_DDRAM_VAL   = 8'h80;
   localparam logic [7:0] CMD_CGRAM_MASK   = 8'hC0, CMD_CGRAM_VAL   = 8'h40;
   localparam logic [7:0] CMD_FUNC_MASK    = 8'hE0, CMD_FUNC_VAL    = 8'h20;
   localparam logic [7:0] CMD_SHIFT_MASK   = 8'hF0, CMD_SHIFT_VAL   = 8'h10;
   localparam logic [7:0] CMD_DISPLAY_MASK = 8'hF8, CMD_DISPLAY_VAL = 8'h08;
   localparam logic [7:0] CMD_ENTRY_MASK   = 8'hFC, CMD_ENTRY_VAL   = 8'h04;
   localparam logic [7:0] CMD_HOME_MASK    = 8'hFE, CMD_HOME_VAL    = 8'h02;
   localparam logic [7:0] CMD_CLEAR_MASK   = 8'hFF, CMD_CLEAR_VAL   = 8'h01;

   typedef enum logic [3:0] {
      CMD_NOP,
      CMD_CLEAR,
      CMD_HOME,
      CMD_ENTRY,
      CMD_DISPLAY,
      CMD_SHIFT,
      CMD_FUNC,
      CMD_CGRAM,
      CMD_DDRAM
   } cmd_e;

   typedef enum logic {
      PH_HIGH,
      PH_LOW
   } phase_e;

   typedef struct packed {
      logic       hit;
      logic [4:0] idx;
   } buf_loc_t;

   function automatic cmd_e decode_cmd(input logic [7:0] b);
      cmd_e c;
      if ((b & CMD_DDRAM_MASK) == CMD_DDRAM_VAL)            c = CMD_DDRAM;
      else if ((b & CMD_CGRAM_MASK) == CMD_CGRAM_VAL)       c = CMD_CGRAM;
      else if ((b & CMD_FUNC_MASK) == CMD_FUNC_VAL)         c = CMD_FUNC;
      else if ((b & CMD_SHIFT_MASK) == CMD_SHIFT_VAL)       c = CMD_SHIFT;
      else if ((b & CMD_DISPLAY_MASK) == CMD_DISPLAY_VAL)   c = CMD_DISPLAY;
      else if ((b & CMD_ENTRY_MASK) == CMD_ENTRY_VAL)       c = CMD_ENTRY;
      else if ((b & CMD_HOME_MASK) == CMD_HOME_VAL)         c = CMD_HOME;
      else if ((b & CMD_CLEAR_MASK) == CMD_CLEAR_VAL)       c = CMD_CLEAR;
      else                                                  c = CMD_NOP;
      return c;
   endfunction

   // Only the first 16 columns of each DDRAM line are mirrored in the shadow buffer.
   function automatic buf_loc_t map_addr(input logic [6:0] a);
      buf_loc_t loc;
      loc.hit = 1'b0;
      loc.idx = {1'b0, a[3:0]};
      if (a[6:4] == LINE1_BASE[6:4]) begin
         loc.hit = 1'b1;
      end else if (a[6:4] == LINE2_BASE[6:4]) begin
         loc.hit = 1'b1;
         loc.idx = {1'b1, a[3:0]};
      end
      return loc;
   endfunction

endpackage

// File: rtl/lcd_rx_sync.sv
// Synchronizes the asynchronous LCD bus pins and emits a one-cycle strobe on each
// falling edge of E, together with RS, RW and DB sampled from the same stage.
module lcd_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rs_i,
   input  logic       e_i,
   input  logic       rw_i,
   input  logic [3:0] db_i,
   output logic       strobe_o,
   output logic       rs_o,
   output logic       rw_o,
   output logic [3:0] db_o
);

   logic [6:0] stage_q [SYNC_STAGES];
   logic [6:0] last;
   logic       e_prev_q;
   logic       strobe_q;
   logic       rs_q;
   logic       rw_q;
   logic [3:0] db_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= {rs_i, e_i, rw_i, db_i};
         for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign last = stage_q[SYNC_STAGES-1];

   // Capture is registered so that the strobe lands one cycle after the edge is seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_prev_q <= 1'b0;
         strobe_q <= 1'b0;
         rs_q     <= 1'b0;
         rw_q     <= 1'b0;
         db_q     <= '0;
      end else begin
         e_prev_q <= last[5];
         strobe_q <= e_prev_q & ~last[5];
         rs_q     <= last[6];
         rw_q     <= last[4];
         db_q     <= last[3:0];
      end
   end

   assign strobe_o = strobe_q;
   assign rs_o     = rs_q;
   assign rw_o     = rw_q;
   assign db_o     = db_q;

endmodule

// File: rtl/lcd_hd44780_rx.sv
// HD44780 4-bit bus receiver: assembles nibbles into bytes, models controller state
// (address counter, entry mode, bus width, busy) and keeps a 2x16 character shadow.
module lcd_hd44780_rx
   import lcd_rx_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int BUSY_CYCLES  = 2000,
   parameter int CLEAR_CYCLES = 82000
) (
   input  logic       clk_qzt,
   input  logic       reset,
   input  logic [1:0] lcd_flags,
   input  logic [3:0] lcd_data,
   input  logic       lcd_rw,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_char,
   output logic [6:0] cur_addr,
   output logic       mode_4bit,
   output logic       entry_inc,
   output logic       display_on,
   output logic       busy,
   output logic       byte_valid,
   output logic       byte_rs,
   output logic [7:0] byte_val,
   output logic       err
);

   localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES);
   localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES);

   logic       strobe;
   logic       s_rs;
   logic       s_rw;
   logic [3:0] s_db;

   lcd_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk      (clk_qzt),
      .rst_n    (reset),
      .rs_i     (lcd_flags[1]),
      .e_i      (lcd_flags[0]),
      .rw_i     (lcd_rw),
      .db_i     (lcd_data),
      .strobe_o (strobe),
      .rs_o     (s_rs),
      .rw_o     (s_rw),
      .db_o     (s_db)
   );

   phase_e           phase_q;
   logic [3:0]       hi_q;
   logic             hi_rs_q;
   logic [6:0]       cur_addr_q;
   logic             mode_4bit_q;
   logic             entry_inc_q;
   logic             display_on_q;
   logic [CNT_W-1:0] busy_cnt_q;
   logic             byte_valid_q;
   logic             byte_rs_q;
   logic [7:0]       byte_val_q;
   logic             err_q;

   logic             byte_ready_d;
   logic [7:0]       byte_d;
   logic             byte_rs_d;
   logic             nib_err_d;
   cmd_e             cmd_d;
   logic             is_cmd_d;
   buf_loc_t         loc_d;
   logic             wr_en_d;
   logic             clear_d;
   logic             long_busy_d;
   logic             busy_now;

   always_comb begin
      byte_ready_d = 1'b0;
      byte_d       = '0;
      byte_rs_d    = s_rs;
      nib_err_d    = 1'b0;
      if (strobe && !s_rw) begin
         if (!mode_4bit_q) begin
            byte_ready_d = 1'b1;
            byte_d       = {s_db, 4'h0};
         end else if (phase_q == PH_LOW) begin
            if (s_rs != hi_rs_q) begin
               nib_err_d = 1'b1;
            end else begin
               byte_ready_d = 1'b1;
               byte_d       = {hi_q, s_db};
            end
         end
      end
   end

   assign cmd_d       = decode_cmd(byte_d);
   assign is_cmd_d    = byte_ready_d && !byte_rs_d;
   assign loc_d       = map_addr(cur_addr_q);
   assign wr_en_d     = byte_ready_d && byte_rs_d && loc_d.hit;
   assign clear_d     = is_cmd_d && (cmd_d == CMD_CLEAR);
   assign long_busy_d = is_cmd_d && ((cmd_d == CMD_CLEAR) || (cmd_d == CMD_HOME));
   assign busy_now    = (busy_cnt_q != '0);

   always_ff @(posedge clk_qzt or negedge reset) begin
      if (!reset) begin
         phase_q      <= PH_HIGH;
         hi_q         <= '0;
         hi_rs_q      <= 1'b0;
         cur_addr_q   <= '0;
         mode_4bit_q  <= 1'b0;
         entry_inc_q  <= 1'b1;
         display_on_q <= 1'b0;
         busy_cnt_q   <= '0;
         byte_valid_q <= 1'b0;
         byte_rs_q    <= 1'b0;
         byte_val_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         byte_valid_q <= byte_ready_d;
         err_q        <= nib_err_d |
                         (byte_ready_d & (busy_now | (is_cmd_d & (cmd_d == CMD_CGRAM))));
         if (byte_ready_d) begin
            byte_rs_q  <= byte_rs_d;
            byte_val_q <= byte_d;
            busy_cnt_q <= long_busy_d ? CLEAR_LOAD : BUSY_LOAD;
         end else if (busy_now) begin
            busy_cnt_q <= busy_cnt_q - 1'b1;
         end

         // A mismatched low nibble restarts the byte with itself as the new high half.
         if (strobe && !s_rw && mode_4bit_q) begin
            case (phase_q)
               PH_HIGH: begin
                  hi_q    <= s_db;
                  hi_rs_q <= s_rs;
                  phase_q <= PH_LOW;
               end
               PH_LOW: begin
                  if (nib_err_d) begin
                     hi_q    <= s_db;
                     hi_rs_q <= s_rs;
                  end else begin
                     phase_q <= PH_HIGH;
                  end
               end
               default: phase_q <= PH_HIGH;
            endcase
         end

         if (byte_ready_d) begin
            if (byte_rs_d) begin
               cur_addr_q <= entry_inc_q ? cur_addr_q + 7'd1 : cur_addr_q - 7'd1;
            end else begin
               case (cmd_d)
                  CMD_DDRAM:   cur_addr_q <= byte_d[6:0];
                  CMD_FUNC: begin
                     mode_4bit_q <= ~byte_d[4];
                     phase_q     <= PH_HIGH;
                  end
                  CMD_SHIFT:   cur_addr_q <= byte_d[2] ? cur_addr_q + 7'd1 : cur_addr_q - 7'd1;
                  CMD_DISPLAY: display_on_q <= byte_d[2];
                  CMD_ENTRY:   entry_inc_q <= byte_d[1];
                  CMD_HOME:    cur_addr_q <= '0;
                  CMD_CLEAR: begin
                     cur_addr_q  <= '0;
                     entry_inc_q <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // Valid bits live in flops so a clear can wipe the whole buffer in one cycle.
   logic valid_q [BUF_DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_valid
         always_ff @(posedge clk_qzt or negedge reset) begin
            if (!reset) begin
               valid_q[gi] <= 1'b0;
            end else if (clear_d) begin
               valid_q[gi] <= 1'b0;
            end else if (wr_en_d && (loc_d.idx == 5'(gi))) begin
               valid_q[gi] <= 1'b1;
            end
         end
      end
   endgenerate

   logic [7:0] mem [BUF_DEPTH];
   logic [7:0] mem_rd_q;
   logic       valid_rd_q;

   always_ff @(posedge clk_qzt) begin
      if (wr_en_d) mem[loc_d.idx] <= byte_d;
      mem_rd_q <= mem[rd_addr];
   end

   always_ff @(posedge clk_qzt or negedge reset) begin
      if (!reset) valid_rd_q <= 1'b0;
      else        valid_rd_q <= valid_q[rd_addr];
   end

   assign rd_char    = valid_rd_q ? mem_rd_q : BLANK_CHAR;
   assign cur_addr   = cur_addr_q;
   assign mode_4bit  = mode_4bit_q;
   assign entry_inc  = entry_inc_q;
   assign display_on = display_on_q;
   assign busy       = busy_now;
   assign byte_valid = byte_valid_q;
   assign byte_rs    = byte_rs_q;
   assign byte_val   = byte_val_q;
   assign err        = err_q;

endmodule

// File: doc/lcd_hd44780_rx.md
Name: lcd_hd44780_rx

Overview:
- Receiving end of the 4-bit HD44780 bus that the debug LCD driver transmits on: RS, E and DB[7:4].
- Decodes nibble strobes into command and data bytes and maintains a 2x16 character shadow buffer.
- Models controller state: DDRAM address counter, entry mode and 4/8-bit mode.
- Used as a loopback and self-check target for the LCD debug path, and as a readback source for the board LEDs.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on the asynchronous bus inputs.
- BUSY_CYCLES, 2000, busy duration after a normal byte (40 us at 50 MHz).
- CLEAR_CYCLES, 82000, busy duration after clear/home (1.64 ms).

Ports:
- clk_qzt  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- lcd_flags  in  2  {RS, E} from the transmitter; asynchronous to clk_qzt.
- lcd_data  in  4  DB[7:4].
- lcd_rw  in  1  strobes are ignored while high.
- rd_addr  in  5  buffer read index: 0-15 = line 1, 16-31 = line 2.
- rd_char  out  8  character at rd_addr, registered, 1-cycle latency.
- cur_addr  out  7  DDRAM address counter.
- mode_4bit  out  1  1 after a function set with DL=0.
- entry_inc  out  1  entry-mode increment flag.
- display_on  out  1  D bit of display control.
- busy  out  1  controller busy model.
- byte_valid  out  1  1-cycle pulse when a complete byte is decoded.
- byte_rs  out  1  RS of that byte.
- byte_val  out  8  value of that byte.
- err  out  1  1-cycle pulse on a protocol violation.

Behaviour:
- Reset (async assert, sync release) sets:
  - cur_addr=0, entry_inc=1, mode_4bit=0, display_on=0;
  - busy, byte_valid, err, byte_rs and byte_val all 0;
  - nibble phase = HIGH;
  - all 32 buffer valid bits cleared, so rd_char reads 0x20.
- Input path: RS, E, DB and RW pass through SYNC_STAGES flops. A falling edge on synchronized E captures RS and DB from the same stage. The capture happens SYNC_STAGES+1 cycles after the pin edge. A rising edge has no effect.
- 8-bit mode (mode_4bit=0):
  - Each strobe forms byte {DB,4'h0} and is decoded immediately.
- 4-bit mode:
  - HIGH phase stores the nibble and its RS, then the phase moves to LOW.
  - LOW phase completes byte {hi,lo} and returns the phase to HIGH.
  - If RS in LOW phase differs from the stored RS: pulse err, discard the stored nibble, and treat the current nibble as a new HIGH nibble.
- A decoded byte pulses byte_valid with byte_rs and byte_val in the cycle after capture. State updates land in that same cycle.
- Command decode (RS=0), highest set bit wins:
  - 1xxxxxxx: cur_addr=byte[6:0].
  - 01xxxxxx: CGRAM access, unsupported; pulse err, no state change.
  - 001Dxxxx: function set; mode_4bit=!D, nibble phase=HIGH.
  - 0001Sxxx: cursor shift; cur_addr +1 if bit2=1, else -1.
  - 00001Dxx: display control; display_on=bit2.
  - 000001Ix: entry mode; entry_inc=bit1.
  - 0000001x: home; cur_addr=0; busy for CLEAR_CYCLES.
  - 00000001: clear; all valid bits cleared in one cycle, cur_addr=0, entry_inc=1; busy for CLEAR_CYCLES.
  - 00000000: no-op.
- Data (RS=1):
  - cur_addr 0x00-0x0F writes index cur_addr[3:0].
  - cur_addr 0x40-0x4F writes index 16+cur_addr[3:0].
  - Any other address is not stored.
  - Every data byte then steps cur_addr by ±1 per entry_inc.
- cur_addr arithmetic is 7-bit modulo 128: 0x7F+1 -> 0x00, 0x00-1 -> 0x7F.
- Busy model: every decoded byte reloads the busy counter, with CLEAR_CYCLES for clear/home and BUSY_CYCLES otherwise; busy=1 while the counter is nonzero.
  - A byte decoded while busy=1 is still executed, pulses err, and reloads the counter.
- Strobes with synchronized RW=1 are ignored entirely: no phase change and no err.
- A reset asserted mid-byte discards the stored nibble.

Decomposition:
- Package lcd_rx_pkg holds:
  - command prefix masks/values;
  - line base addresses 7'h00 and 7'h40;
  - blank character 8'h20;
  - buffer geometry constants (LINE_LEN=16, LINES=2).
- Sub-module lcd_rx_sync: parametric synchronizer plus E falling-edge detector. Outputs a strobe pulse with sampled RS, DB and RW.

Test Plan:
- Reset, then read all 32 indexes -> every rd_char=0x20; cur_addr=0, entry_inc=1, mode_4bit=0.
- Init sequence, busy gaps honoured, err=0 throughout:
  - 8-bit strobes 0x3, 0x3, 0x3, 0x2 -> mode_4bit=1 after the 0x2 strobe.
  - Then 4-bit 0x28, 0x0C, 0x06, 0x01 -> display_on=1, entry_inc=1.
- Send cmd 0x80, then data 'H' (0x48) and 'I' (0x49) -> rd_char[0]=0x48, rd_char[1]=0x49, cur_addr=0x02.
- Send cmd 0xCF, data 0x41, data 0x42 -> rd_char[31]=0x41, cur_addr=0x51; second byte not stored.
- Decrement and wrap: cmd 0x04, cmd 0x80, data 0x5A -> rd_char[0]=0x5A, cur_addr=0x7F.
- Violations, each pulsing err for exactly 1 cycle:
  - High nibble with RS=1 followed by low nibble with RS=0 -> err, no byte_valid; next nibble forms the low half.
  - A byte sent 100 cycles after the previous one -> err, and the byte is still applied.
